// File: rtl/ram_read_arbiter.sv
`timescale 1ns/1ps
// ram_read_arbiter
// Shares the single read port of the cellular RAM controller between several
// read requesters (index 0 = VGA background fetch, then the sprite engines).
// A winner is chosen in IDLE, its address is latched onto ram_addr, a one-cycle
// ram_start is issued, and the controller's ram_done (bounded by a timeout) is
// turned into a one-cycle rd_valid for the winner. Every output is registered.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-requester read request level
//   req_addr    : flattened requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt         : one-hot grant, held for the whole transaction
//   rd_valid    : one-hot one-cycle pulse, rd_data valid for that requester
//   rd_data     : returned read word, held until the next capture
//   rd_timeout  : one-cycle pulse when a read is abandoned
//   ram_addr    : address to the RAM controller
//   ram_start   : one-cycle read start to the RAM controller
//   ram_done    : controller read complete, ram_data valid this cycle
//   ram_data    : controller read data
module ram_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 63,
    parameter bit PRIO0   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_timeout,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_start,
    input  logic                      ram_done,
    input  logic [DATA_W-1:0]         ram_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Last WAIT cycle before the abort: the timeout pulse then lands exactly
    // TIMEOUT cycles after WAIT was entered.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [IW-1:0]         win, win_nxt;
    logic [IW-1:0]         rr, rr_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [IW-1:0]         win_sel;
    logic [NUM_REQ-1:0]    gnt_nxt;
    logic [NUM_REQ-1:0]    rd_valid_nxt;
    logic [DATA_W-1:0]     rd_data_nxt;
    logic                  rd_timeout_nxt;
    logic [ADDR_W-1:0]     ram_addr_nxt;
    logic                  ram_start_nxt;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1)
            return '0;
        return idx + IW'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Requester 0 may pre-empt the rotation; otherwise search upward from the
    // round-robin pointer with wrap-around.
    function automatic logic [IW-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [IW-1:0]      ptr);
        logic [IW-1:0] cand;
        logic [IW-1:0] w;
        logic          found;
        w     = '0;
        found = 1'b0;
        cand  = ptr;
        if (PRIO0 && r[0]) begin
            found = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[cand]) begin
                w     = cand;
                found = 1'b1;
            end
            cand = next_ptr(cand);
        end
        return w;
    endfunction

    assign win_sel = pick_winner(req, rr);

    always_comb begin
        state_nxt      = state;
        win_nxt        = win;
        rr_nxt         = rr;
        timer_nxt      = timer;
        gnt_nxt        = gnt;
        rd_valid_nxt   = '0;
        rd_data_nxt    = rd_data;
        rd_timeout_nxt = 1'b0;
        ram_addr_nxt   = ram_addr;
        ram_start_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt       = win_sel;
                    ram_addr_nxt  = req_addr[int'(win_sel)*ADDR_W +: ADDR_W];
                    gnt_nxt       = onehot(win_sel);
                    ram_start_nxt = 1'b1;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ram_done) begin
                    rd_data_nxt  = ram_data;
                    rd_valid_nxt = gnt;
                    state_nxt    = RESP;
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (timer == TIMER_LAST) begin
                        rd_timeout_nxt = 1'b1;
                        gnt_nxt        = '0;
                        rr_nxt         = next_ptr(win);
                        state_nxt      = IDLE;
                    end
                end
            end
            RESP: begin
                gnt_nxt   = '0;
                rr_nxt    = next_ptr(win);
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            win        <= '0;
            rr         <= '0;
            timer      <= '0;
            gnt        <= '0;
            rd_valid   <= '0;
            rd_data    <= '0;
            rd_timeout <= 1'b0;
            ram_addr   <= '0;
            ram_start  <= 1'b0;
        end else begin
            state      <= state_nxt;
            win        <= win_nxt;
            rr         <= rr_nxt;
            timer      <= timer_nxt;
            gnt        <= gnt_nxt;
            rd_valid   <= rd_valid_nxt;
            rd_data    <= rd_data_nxt;
            rd_timeout <= rd_timeout_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_start  <= ram_start_nxt;
        end
    end

endmodule

// File: tb/tb_ram_read_arbiter.sv
`timescale 1ns/1ps
// Testbench for ram_read_arbiter: one instance with requester-0 priority
// (dut_a) and one pure round-robin instance (dut_b), sharing clk and rst.
// The bench acts as the RAM controller and predicts winners from the
// arbitration rules with a simple pointer model.
module tb_ram_read_arbiter;
    localparam int N  = 3;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int TO = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ptr_a  = 0;
    int ptr_b  = 0;

    logic [N-1:0]    req_a, req_b;
    logic [AW-1:0]   a_tab [N];
    logic [AW-1:0]   b_tab [N];
    logic [N*AW-1:0] addr_a, addr_b;
    logic            done_a, done_b;
    logic [DW-1:0]   data_a, data_b;
    logic [N-1:0]    gnt_a, gnt_b, vld_a, vld_b;
    logic [DW-1:0]   rdata_a, rdata_b;
    logic            tmo_a, tmo_b, start_a, start_b;
    logic [AW-1:0]   raddr_a, raddr_b;

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i*AW +: AW] = a_tab[i];
            addr_b[i*AW +: AW] = b_tab[i];
        end
    end

    ram_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO0(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .gnt(gnt_a),
        .rd_valid(vld_a), .rd_data(rdata_a), .rd_timeout(tmo_a), .ram_addr(raddr_a),
        .ram_start(start_a), .ram_done(done_a), .ram_data(data_a));

    ram_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO0(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .gnt(gnt_b),
        .rd_valid(vld_b), .rd_data(rdata_b), .rd_timeout(tmo_b), .ram_addr(raddr_b),
        .ram_start(start_b), .ram_done(done_b), .ram_data(data_b));

    // Reference arbitration: requester 0 first when prioritised, otherwise the
    // first requesting index at or after the pointer, wrapping around.
    function automatic int exp_pick(input logic [N-1:0] r, input int ptr, input bit prio);
        if (prio && r[0]) return 0;
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({gnt_a, vld_a, rdata_a, tmo_a, raddr_a, start_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", {gnt_a, vld_a, rdata_a, tmo_a, raddr_a, start_a});
        end
        checks++;
        if ({gnt_b, vld_b, rdata_b, tmo_b, raddr_b, start_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", {gnt_b, vld_b, rdata_b, tmo_b, raddr_b, start_b});
        end
        rst = 1'b0;
        ptr_a = 0;
        ptr_b = 0;
    endtask

    task automatic test_single_read;
        a_tab[1] = 26'h0000ABC;
        req_a = 3'b010;
        tick;
        checks++;
        if ({gnt_a, start_a, raddr_a} !== {3'b010, 1'b1, 26'h0000ABC}) begin
            errors++;
            $display("FAIL single_grant got gnt=%b start=%b addr=%h exp 010 1 0000abc", gnt_a, start_a, raddr_a);
        end
        req_a = 3'b000;
        tick;
        tick;
        done_a = 1'b1;
        data_a = 16'h5A5A;
        tick;
        done_a = 1'b0;
        checks++;
        if ({vld_a, rdata_a, gnt_a} !== {3'b010, 16'h5A5A, 3'b010}) begin
            errors++;
            $display("FAIL single_resp got vld=%b data=%h gnt=%b exp 010 5a5a 010", vld_a, rdata_a, gnt_a);
        end
        ptr_a = 2;
        tick;
        checks++;
        if ({gnt_a, vld_a} !== 6'b0) begin
            errors++;
            $display("FAIL single_release got gnt=%b vld=%b exp 000 000", gnt_a, vld_a);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [N-1:0] r;
        int w;
        a_tab[1] = 26'h0000123;
        req_a = 3'b010;
        tick;
        checks++;
        if (gnt_a !== 3'b010) begin
            errors++;
            $display("FAIL midrst_grant got %b exp 010", gnt_a);
        end
        req_a = 3'b000;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptr_a = 0;
        checks++;
        if ({gnt_a, vld_a, rdata_a, tmo_a, raddr_a, start_a} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got %h exp 0", {gnt_a, vld_a, rdata_a, tmo_a, raddr_a, start_a});
        end
        done_a = 1'b1;
        data_a = 16'hBEEF;
        tick;
        done_a = 1'b0;
        tick;
        checks++;
        if ({vld_a, gnt_a} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_no_valid got vld=%b gnt=%b exp 000 000", vld_a, gnt_a);
        end
        for (int t = 0; t < 2; t++) begin
            r = (t == 0) ? 3'b110 : 3'b100;
            w = exp_pick(r, ptr_a, 1'b1);
            a_tab[w] = AW'($urandom);
            req_a = r;
            tick;
            checks++;
            if ({gnt_a, raddr_a} !== {oh(w), a_tab[w]}) begin
                errors++;
                $display("FAIL midrst_regrant got gnt=%b addr=%h exp %b %h", gnt_a, raddr_a, oh(w), a_tab[w]);
            end
            req_a = 3'b000;
            tick;
            done_a = 1'b1;
            data_a = DW'($urandom);
            tick;
            done_a = 1'b0;
            checks++;
            if ({vld_a, rdata_a} !== {oh(w), data_a}) begin
                errors++;
                $display("FAIL midrst_resp got vld=%b data=%h exp %b %h", vld_a, rdata_a, oh(w), data_a);
            end
            ptr_a = (w + 1) % N;
            tick;
        end
    endtask

    task automatic test_priority;
        int exp_seq [7] = '{0, 0, 0, 1, 2, 1, 2};
        int w;
        for (int i = 0; i < N; i++) a_tab[i] = AW'($urandom);
        for (int it = 0; it < 7; it++) begin
            req_a = (it < 3) ? 3'b111 : 3'b110;
            w = exp_seq[it];
            tick;
            checks++;
            if ({gnt_a, start_a, raddr_a} !== {oh(w), 1'b1, a_tab[w]}) begin
                errors++;
                $display("FAIL prio_grant[%0d] got gnt=%b start=%b addr=%h exp %b 1 %h", it, gnt_a, start_a, raddr_a, oh(w), a_tab[w]);
            end
            tick;
            done_a = 1'b1;
            data_a = DW'($urandom);
            tick;
            done_a = 1'b0;
            checks++;
            if ({vld_a, rdata_a} !== {oh(w), data_a}) begin
                errors++;
                $display("FAIL prio_resp[%0d] got vld=%b data=%h exp %b %h", it, vld_a, rdata_a, oh(w), data_a);
            end
            ptr_a = (w + 1) % N;
            tick;
        end
        req_a = 3'b000;
        tick;
    endtask

    task automatic test_round_robin;
        int exp_seq [4] = '{0, 1, 2, 0};
        int w;
        int last_vld;
        last_vld = 0;
        for (int i = 0; i < N; i++) b_tab[i] = AW'($urandom);
        req_b = 3'b111;
        for (int it = 0; it < 4; it++) begin
            w = exp_seq[it];
            tick;
            checks++;
            if ({gnt_b, start_b, raddr_b} !== {oh(w), 1'b1, b_tab[w]}) begin
                errors++;
                $display("FAIL rr_grant[%0d] got gnt=%b start=%b addr=%h exp %b 1 %h", it, gnt_b, start_b, raddr_b, oh(w), b_tab[w]);
            end
            tick;
            done_b = 1'b1;
            data_b = DW'($urandom);
            tick;
            done_b = 1'b0;
            checks++;
            if ({vld_b, rdata_b} !== {oh(w), data_b}) begin
                errors++;
                $display("FAIL rr_resp[%0d] got vld=%b data=%h exp %b %h", it, vld_b, rdata_b, oh(w), data_b);
            end
            if (it > 0) begin
                checks++;
                if (cyc - last_vld != 4) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d] got %0d exp 4", it, cyc - last_vld);
                end
            end
            last_vld = cyc;
            ptr_b = (w + 1) % N;
            if (it == 3) req_b = 3'b000;
            tick;
        end
        tick;
    endtask

    task automatic test_timeout;
        int wait_cnt;
        bit bad_hold;
        bad_hold = 1'b0;
        req_b = 3'b100;
        tick;
        checks++;
        if ({gnt_b, start_b} !== {3'b100, 1'b1}) begin
            errors++;
            $display("FAIL tmo_grant got gnt=%b start=%b exp 100 1", gnt_b, start_b);
        end
        req_b = 3'b000;
        tick;
        wait_cnt = 0;
        while (tmo_b !== 1'b1 && wait_cnt < 100) begin
            if (vld_b !== 3'b000 || gnt_b !== 3'b100 || start_b !== 1'b0) bad_hold = 1'b1;
            tick;
            wait_cnt++;
        end
        checks++;
        if (wait_cnt != TO) begin
            errors++;
            $display("FAIL tmo_latency got %0d exp %0d", wait_cnt, TO);
        end
        checks++;
        if (bad_hold || {gnt_b, vld_b} !== 6'b0) begin
            errors++;
            $display("FAIL tmo_outputs got hold_err=%0d gnt=%b vld=%b exp 0 000 000", bad_hold, gnt_b, vld_b);
        end
        ptr_b = (2 + 1) % N;
        req_b = 3'b111;
        tick;
        checks++;
        if ({tmo_b, gnt_b} !== {1'b0, oh(exp_pick(3'b111, ptr_b, 1'b0))}) begin
            errors++;
            $display("FAIL tmo_next_grant got tmo=%b gnt=%b exp 0 001", tmo_b, gnt_b);
        end
        req_b = 3'b000;
        tick;
        done_b = 1'b1;
        data_b = 16'h1234;
        tick;
        done_b = 1'b0;
        checks++;
        if ({vld_b, rdata_b} !== {3'b001, 16'h1234}) begin
            errors++;
            $display("FAIL tmo_after_resp got vld=%b data=%h exp 001 1234", vld_b, rdata_b);
        end
        ptr_b = 1;
        tick;
    endtask

    task automatic test_addr_stability;
        a_tab[1] = 26'h10;
        req_a = 3'b010;
        tick;
        checks++;
        if ({gnt_a, raddr_a} !== {3'b010, 26'h10}) begin
            errors++;
            $display("FAIL stab_grant got gnt=%b addr=%h exp 010 0000010", gnt_a, raddr_a);
        end
        tick;
        a_tab[1] = 26'h20;
        req_a = 3'b000;
        tick;
        checks++;
        if (raddr_a !== 26'h10) begin
            errors++;
            $display("FAIL stab_addr got %h exp 0000010", raddr_a);
        end
        done_a = 1'b1;
        data_a = 16'hC3C3;
        tick;
        done_a = 1'b0;
        checks++;
        if ({vld_a, rdata_a, raddr_a} !== {3'b010, 16'hC3C3, 26'h10}) begin
            errors++;
            $display("FAIL stab_resp got vld=%b data=%h addr=%h exp 010 c3c3 0000010", vld_a, rdata_a, raddr_a);
        end
        ptr_a = 2;
        tick;
        done_a = 1'b1;
        data_a = 16'hFFFF;
        tick;
        done_a = 1'b0;
        checks++;
        if ({vld_a, gnt_a, start_a, rdata_a} !== {7'b0, 16'hC3C3}) begin
            errors++;
            $display("FAIL stab_idle_done got vld=%b gnt=%b start=%b data=%h exp 000 000 0 c3c3", vld_a, gnt_a, start_a, rdata_a);
        end
        tick;
        checks++;
        if (vld_a !== 3'b000) begin
            errors++;
            $display("FAIL stab_idle_quiet got %b exp 000", vld_a);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] r;
        int w;
        int d;
        for (int it = 0; it < 40; it++) begin
            r = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) a_tab[i] = AW'($urandom);
            w = exp_pick(r, ptr_a, 1'b1);
            req_a = r;
            tick;
            checks++;
            if ({gnt_a, start_a, raddr_a} !== {oh(w), 1'b1, a_tab[w]}) begin
                errors++;
                $display("FAIL rand_grant[%0d] got gnt=%b start=%b addr=%h exp %b 1 %h", it, gnt_a, start_a, raddr_a, oh(w), a_tab[w]);
            end
            if ($urandom_range(0, 1) == 1) a_tab[w] = AW'($urandom);
            req_a = N'($urandom_range(0, 7));
            tick;
            d = $urandom_range(0, 5);
            for (int k = 0; k < d; k++) begin
                checks++;
                if ({vld_a, gnt_a, start_a, tmo_a} !== {3'b000, oh(w), 2'b00}) begin
                    errors++;
                    $display("FAIL rand_wait[%0d] got vld=%b gnt=%b start=%b tmo=%b exp 000 %b 0 0", it, vld_a, gnt_a, start_a, tmo_a, oh(w));
                end
                tick;
            end
            done_a = 1'b1;
            data_a = DW'($urandom);
            tick;
            done_a = 1'b0;
            checks++;
            if ({vld_a, rdata_a} !== {oh(w), data_a}) begin
                errors++;
                $display("FAIL rand_resp[%0d] got vld=%b data=%h exp %b %h", it, vld_a, rdata_a, oh(w), data_a);
            end
            ptr_a = (w + 1) % N;
            req_a = 3'b000;
            tick;
            checks++;
            if (gnt_a !== 3'b000) begin
                errors++;
                $display("FAIL rand_release[%0d] got %b exp 000", it, gnt_a);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        req_a  = '0;
        req_b  = '0;
        done_a = 1'b0;
        done_b = 1'b0;
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < N; i++) begin
            a_tab[i] = '0;
            b_tab[i] = '0;
        end
        test_reset;
        test_single_read;
        test_reset_mid_wait;
        test_priority;
        test_round_robin;
        test_timeout;
        test_addr_stability;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
